alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
// - Pipelined, parametrised successor to the team's combinational 64-bit ALU: same 3-bit opcode set, any even WIDTH.
// - Adds valid/ready handshake, a 2-stage split-carry adder and registered status flags (C, Z, N, V).
// - Sits between the operand-fetch stage and the writeback / flag-register path of the datapath.
// PARAMETERS
// - WIDTH  64  operand/result width; even, >= 4; LO = WIDTH/2 low-half width, HI = WIDTH-LO
// PORTS
// - clk        in   1      single clock, all state on rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      operand beat valid
// - in_ready   out  1      block can accept a beat this cycle
// - in_a       in   WIDTH  operand A
// - in_b       in   WIDTH  operand B
// - in_op      in   3      opcode (encoding below)
// - out_valid  out  1      result beat valid
// - out_ready  in   1      downstream accepts result
// - out_res    out  WIDTH  result
// - out_c      out  1      carry out (arith ops), 0 otherwise
// - out_z      out  1      out_res == 0
// - out_n      out  1      out_res[WIDTH-1]
// - out_v      out  1      signed overflow (arith ops), 0 otherwise
// BEHAVIOUR
// - Opcodes: 000 A+B; 001 A-B (A+~B+1); 010 B-A (B+~A+1); 011 A|B; 100 A&B; 101 A^B; 110 A~^B; 111 result 0.
// - Handshake: beat accepted when in_valid & in_ready; result consumed when out_valid & out_ready.
// - Pipeline advance: adv = out_ready | ~out_valid; in_ready = adv (combinational, no in_valid dependency).
// - Whole pipe holds (all stage regs frozen) when ~adv; no beat dropped or duplicated.
// - Stage 1 (on accept): register op, operand-select (op_a, op_b, cin), low LO-bit sum and carry c_lo.
// - Stage 2: high HI-bit sum with c_lo as carry-in; logic ops computed here; register res and flags into out regs.
// - Latency: exactly 2 cycles accept -> out_valid with no stall; throughput 1 beat/cycle.
// - Bubbles: stage valids advance with adv; invalid slots never raise out_valid.
// - C: carry from bit WIDTH-1 of the full adder (for subtract, 1 = no borrow); 0 for ops 011-111.
// - V: (op_a[MSB]==op_b[MSB]) & (sum[MSB]!=op_a[MSB]) using selected (inverted) operands; 0 for ops 011-111.
// - Z, N always computed from out_res, incl. op 111 (Z=1, N=0).
// - Reset: all stage valids, out_valid, out_res and all flags to 0; in_ready = 1 the cycle after reset.
// - Reset mid-operation: in-flight beats discarded, no output produced for them.
// - Output data/flags stable while out_valid & ~out_ready.
// - Simultaneous accept and consume with full pipe: both occur, occupancy unchanged.
// STRUCTURE
// - alu_pkg: opcode localparams (OP_ADD .. OP_ZERO), 3-bit opcode typedef, is_arith() function.
// - Sub-module alu_pipe_reg: WIDTH-parametrised valid+data register with enable and sync clear; used per stage.
// - Top holds operand select, split adder, logic mux and flag logic only.
// TESTING (WIDTH=64 unless noted)
// - Reset then op 000, A=FFFF_FFFF_FFFF_FFFF, B=1 -> 2 cycles later res=0, C=1, Z=1, V=0, N=0.
// - op 001, A=8000_0000_0000_0000, B=1 -> res=7FFF_FFFF_FFFF_FFFF, C=1, V=1, N=0; op 010 A=5,B=3 -> res=FFFF_FFFF_FFFF_FFFE, C=0, N=1.
// - Low-half carry into high: op 000 A=0000_0000_FFFF_FFFF, B=1 -> res=0000_0001_0000_0000, C=0.
// - Logic/zero ops A=F0F0.., B=FF00..: 011/100/101/110 give FFF0../F000../0FF0../F00F.. with C=V=0; op 111 -> res=0, Z=1.
// - Backpressure: stream 5 beats, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while out_valid held, results in order, none lost.
// - Reset with 2 beats in flight -> out_valid=0 thereafter; WIDTH=8 rerun: op 000 A=7F,B=01 -> res=80, V=1, N=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encoding and helpers shared by the pipelined ALU and its testbench.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD  = 3'b000;
    localparam alu_op_t OP_SUB  = 3'b001;
    localparam alu_op_t OP_RSUB = 3'b010;
    localparam alu_op_t OP_OR   = 3'b011;
    localparam alu_op_t OP_AND  = 3'b100;
    localparam alu_op_t OP_XOR  = 3'b101;
    localparam alu_op_t OP_XNOR = 3'b110;
    localparam alu_op_t OP_ZERO = 3'b111;

    // Only the adder-based opcodes produce meaningful carry and overflow.
    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSUB);
    endfunction

endpackage

// File: rtl/alu_pipe_reg.sv
// Pipeline slot: a valid bit plus payload, loaded on enable and cleared by synchronous reset.
module alu_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, split-carry adder and registered C/Z/N/V flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v
);

    localparam int LO   = WIDTH / 2;
    localparam int HI   = WIDTH - LO;
    localparam int S1_W = 3 + 2 * WIDTH + LO + 1;
    localparam int S2_W = WIDTH + 4;

    logic adv;

    // The whole pipe moves together; it only stalls when a finished result is waiting.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             cin;
    logic [LO:0]      lo_sum;

    // Subtractions become additions of an inverted operand with carry-in set.
    always_comb begin
        sel_a = in_a;
        sel_b = in_b;
        cin   = 1'b0;
        case (alu_op_t'(in_op))
            OP_SUB: begin
                sel_b = ~in_b;
                cin   = 1'b1;
            end
            OP_RSUB: begin
                sel_a = in_b;
                sel_b = ~in_a;
                cin   = 1'b1;
            end
            default: ;
        endcase
    end

    assign lo_sum = {1'b0, sel_a[LO-1:0]} + {1'b0, sel_b[LO-1:0]} + {{LO{1'b0}}, cin};

    logic             s1_valid;
    logic [S1_W-1:0]  s1_q;

    alu_pipe_reg #(.WIDTH(S1_W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .d_valid (in_valid),
        .d_data  ({in_op, sel_a, sel_b, lo_sum}),
        .q_valid (s1_valid),
        .q_data  (s1_q)
    );

    alu_op_t          s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [LO-1:0]    s1_lo;
    logic             s1_clo;

    assign s1_op  = s1_q[S1_W-1 -: 3];
    assign s1_a   = s1_q[S1_W-4 -: WIDTH];
    assign s1_b   = s1_q[S1_W-4-WIDTH -: WIDTH];
    assign s1_clo = s1_q[LO];
    assign s1_lo  = s1_q[LO-1:0];

    logic [HI:0]      hi_sum;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res;
    logic             c_flag;
    logic             v_flag;
    logic             z_flag;
    logic             n_flag;

    assign hi_sum = {1'b0, s1_a[WIDTH-1:LO]} + {1'b0, s1_b[WIDTH-1:LO]} + {{HI{1'b0}}, s1_clo};
    assign sum    = {hi_sum[HI-1:0], s1_lo};

    // Logic ops see the unmodified operands because the select stage leaves them untouched.
    always_comb begin
        res    = sum;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (s1_op)
            OP_OR:   res = s1_a | s1_b;
            OP_AND:  res = s1_a & s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_XNOR: res = ~(s1_a ^ s1_b);
            OP_ZERO: res = '0;
            default: ;
        endcase
        if (is_arith(s1_op)) begin
            c_flag = hi_sum[HI];
            v_flag = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        end
    end

    assign z_flag = (res == '0);
    assign n_flag = res[WIDTH-1];

    logic [S2_W-1:0] s2_q;

    alu_pipe_reg #(.WIDTH(S2_W)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .d_valid (s1_valid),
        .d_data  ({res, c_flag, z_flag, n_flag, v_flag}),
        .q_valid (out_valid),
        .q_data  (s2_q)
    );

    assign out_res = s2_q[S2_W-1 -: WIDTH];
    assign out_c   = s2_q[3];
    assign out_z   = s2_q[2];
    assign out_n   = s2_q[1];
    assign out_v   = s2_q[0];

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe at WIDTH=64 and WIDTH=8, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_a, in_b, out_res;
    logic [2:0]  in_op;
    logic        out_c, out_z, out_n, out_v;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8;
    logic [7:0]  in_a_8, in_b_8, out_res_8;
    logic [2:0]  in_op_8;
    logic        out_c_8, out_z_8, out_n_8, out_v_8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_pipe #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_c(out_c), .out_z(out_z), .out_n(out_n), .out_v(out_v)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .in_a(in_a_8), .in_b(in_b_8), .in_op(in_op_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8), .out_res(out_res_8),
        .out_c(out_c_8), .out_z(out_z_8), .out_n(out_n_8), .out_v(out_v_8)
    );

    // Reference: {result[63:0], C, Z, N, V} for a w-bit ALU, using wide integer arithmetic.
    function automatic logic [67:0] ref_alu(input int w, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [64:0] mask, ax, bx, x, y, s;
        logic [63:0] r;
        logic        c, v, z, n;
        mask = (65'd1 << w) - 65'd1;
        ax = {1'b0, a} & mask;
        bx = {1'b0, b} & mask;
        x = ax;
        y = bx;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: s = ax + bx;
            3'd1: begin y = ~bx & mask; s = ax + y + 65'd1; end
            3'd2: begin x = bx; y = ~ax & mask; s = x + y + 65'd1; end
            3'd3: s = ax | bx;
            3'd4: s = ax & bx;
            3'd5: s = ax ^ bx;
            3'd6: s = ~(ax ^ bx) & mask;
            default: s = '0;
        endcase
        if (op <= 3'd2) begin
            c = s[w];
            v = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        end
        r = s[63:0] & mask[63:0];
        z = (r == 64'd0);
        n = r[w-1];
        return {r, c, z, n, v};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_op = 3'd0; in_a = '1; in_b = 64'd1; out_ready = 1'b0;
        in_valid_8 = 1'b1; in_op_8 = 3'd0; in_a_8 = 8'h7F; in_b_8 = 8'h01; out_ready_8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_valid_8 = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, out_res, out_c, out_z, out_n, out_v} !== 69'd0) $display("[TB] FAIL reset_out: got %h expected 0", {out_valid, out_res, out_c, out_z, out_n, out_v});
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({out_valid_8, out_res_8, out_c_8, out_z_8, out_n_8, out_v_8} !== 13'd0) $display("[TB] FAIL reset_out8: got %h expected 0", {out_valid_8, out_res_8, out_c_8, out_z_8, out_n_8, out_v_8});
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [2:0]  vop [9];
        logic [63:0] va [9], vb [9], eres [9];
        logic [3:0]  ef [9];
        vop  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        va   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd5, 64'h0000_0000_FFFF_FFFF,
                 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0,
                 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0};
        vb   = '{64'd1, 64'd1, 64'd3, 64'd1,
                 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00,
                 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00};
        eres = '{64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0000,
                 64'hFFF0_FFF0_FFF0_FFF0, 64'hF000_F000_F000_F000, 64'h0FF0_0FF0_0FF0_0FF0,
                 64'hF00F_F00F_F00F_F00F, 64'd0};
        // flags as {C, Z, N, V}
        ef   = '{4'b1100, 4'b1001, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0100};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = vop[i]; in_a = va[i]; in_b = vb[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            total_cnt++;
            if (out_valid !== 1'b0) $display("[TB] FAIL dir_early_valid[%0d]: got %b expected 0", i, out_valid);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1) $display("[TB] FAIL dir_latency[%0d]: got out_valid=%b expected 1", i, out_valid);
            else pass_cnt++;
            total_cnt++;
            if ({out_res, out_c, out_z, out_n, out_v} !== {eres[i], ef[i]})
                $display("[TB] FAIL dir_result[%0d]: got %h/%b expected %h/%b", i, out_res, {out_c, out_z, out_n, out_v}, eres[i], ef[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [67:0] q[$];
        logic [67:0] e;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 60) && ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom_range(0, 7));
            in_a = {$urandom, $urandom};
            in_b = ($urandom_range(0, 4) == 0) ? ~in_a : {$urandom, $urandom};
            out_ready = (cyc >= 60) || ($urandom_range(0, 3) != 0);
            #1;
            total_cnt++;
            if (in_ready !== (out_ready || !out_valid)) $display("[TB] FAIL rand_in_ready: got %b expected %b", in_ready, out_ready || !out_valid);
            else pass_cnt++;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (q.size() == 0) $display("[TB] FAIL rand_extra: got unexpected result %h expected none", out_res);
                else begin
                    e = q.pop_front();
                    if ({out_res, out_c, out_z, out_n, out_v} !== e)
                        $display("[TB] FAIL rand_result: got %h expected %h", {out_res, out_c, out_z, out_n, out_v}, e);
                    else pass_cnt++;
                end
            end
            if (in_valid && in_ready) q.push_back(ref_alu(64, in_op, in_a, in_b));
        end
        total_cnt++;
        if (q.size() != 0) $display("[TB] FAIL rand_drain: got %0d outstanding expected 0", q.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [67:0] q[$];
        logic [67:0] e;
        logic [68:0] held;
        logic        was_held = 1'b0;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 5);
            in_op = 3'($urandom_range(0, 2));
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            if (was_held) begin
                total_cnt++;
                if ({out_valid, out_res, out_c, out_z, out_n, out_v} !== held)
                    $display("[TB] FAIL bp_stable: got %h expected %h", {out_valid, out_res, out_c, out_z, out_n, out_v}, held);
                else pass_cnt++;
            end
            was_held = 1'b0;
            if (out_valid && !out_ready) begin
                total_cnt++;
                if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready);
                else pass_cnt++;
                held = {out_valid, out_res, out_c, out_z, out_n, out_v};
                was_held = 1'b1;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                got++;
                if (q.size() == 0) $display("[TB] FAIL bp_extra: got unexpected result %h expected none", out_res);
                else begin
                    e = q.pop_front();
                    if ({out_res, out_c, out_z, out_n, out_v} !== e)
                        $display("[TB] FAIL bp_result: got %h expected %h", {out_res, out_c, out_z, out_n, out_v}, e);
                    else pass_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_alu(64, in_op, in_a, in_b));
                sent++;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (got !== 5) $display("[TB] FAIL bp_count: got %0d results expected 5", got);
        else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_a = 64'd10; in_b = 64'd20; out_ready = 1'b0;
        @(negedge clk);
        in_op = 3'd1; in_a = 64'd30; in_b = 64'd4;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1) $display("[TB] FAIL rst_fill: got out_valid=%b expected 1", out_valid);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, out_res, out_c, out_z, out_n, out_v} !== 69'd0)
            $display("[TB] FAIL rst_clear: got %h expected 0", {out_valid, out_res, out_c, out_z, out_n, out_v});
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b0) $display("[TB] FAIL rst_discard[%0d]: got out_valid=%b expected 0", i, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_width8();
        logic [67:0] q[$];
        logic [67:0] e;
        @(negedge clk);
        in_valid_8 = 1'b1; in_op_8 = 3'd0; in_a_8 = 8'h7F; in_b_8 = 8'h01; out_ready_8 = 1'b1;
        @(negedge clk);
        in_valid_8 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({out_valid_8, out_res_8, out_c_8, out_z_8, out_n_8, out_v_8} !== {1'b1, 8'h80, 4'b0011})
            $display("[TB] FAIL w8_directed: got %h expected %h", {out_valid_8, out_res_8, out_c_8, out_z_8, out_n_8, out_v_8}, {1'b1, 8'h80, 4'b0011});
        else pass_cnt++;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            in_valid_8 = (cyc < 40) && ($urandom_range(0, 2) != 0);
            in_op_8 = 3'($urandom_range(0, 7));
            in_a_8 = 8'($urandom);
            in_b_8 = 8'($urandom);
            out_ready_8 = (cyc >= 40) || ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid_8 && out_ready_8) begin
                total_cnt++;
                if (q.size() == 0) $display("[TB] FAIL w8_extra: got unexpected result %h expected none", out_res_8);
                else begin
                    e = q.pop_front();
                    if ({out_res_8, out_c_8, out_z_8, out_n_8, out_v_8} !== e[11:0])
                        $display("[TB] FAIL w8_result: got %h expected %h", {out_res_8, out_c_8, out_z_8, out_n_8, out_v_8}, e[11:0]);
                    else pass_cnt++;
                end
            end
            if (in_valid_8 && in_ready_8) q.push_back(ref_alu(8, in_op_8, {56'd0, in_a_8}, {56'd0, in_b_8}));
        end
        total_cnt++;
        if (q.size() != 0) $display("[TB] FAIL w8_drain: got %0d outstanding expected 0", q.size());
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; out_ready = 1'b0;
        in_valid_8 = 1'b0; in_op_8 = 3'd0; in_a_8 = '0; in_b_8 = '0; out_ready_8 = 1'b0;
        $display("[TB] starting alu_pipe bench");
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_inflight();
        test_width8();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
